// File: rtl/pulse_shape_fir_if.sv
// rtl/pulse_shape_fir_if.sv - sample-stream bundle between the upsampler, the FIR and the DAC side
//
// Purpose: groups the per-rail input symbol stream and the filtered output
//          stream of pulse_shape_fir.
// Signals:
//   en        stage enable (master -> slave)
//   in_valid  in_data qualifier (master -> slave)
//   in_data   2-bit signed symbol: 01=+1, 11=-1, 00=0, 10=-2
//   out_valid one-cycle strobe per filtered sample (slave -> master)
//   out_data  OUT_W-bit signed filtered sample (slave -> master)
// Modports: master = upstream driver / downstream sink, slave = the FIR.
interface pulse_shape_fir_if #(
  parameter int OUT_W = 12
);
  logic                    en;
  logic                    in_valid;
  logic signed [1:0]       in_data;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;

  modport master (
    output en, in_valid, in_data,
    input  out_valid, out_data
  );

  modport slave (
    input  en, in_valid, in_data,
    output out_valid, out_data
  );
endinterface

// File: rtl/pulse_shape_fir.sv
// rtl/pulse_shape_fir.sv - 9-tap symmetric raised-cosine pulse-shaping FIR for one QAM rail
//
// Purpose: filters the 4x zero-stuffed symbol stream with fixed taps
//          -3, 0, 21, 64, 96, 64, 21, 0, -3 (c0 on the newest sample) and
//          emits one signed sample per accepted input, 2 clocks after the
//          acceptance edge.
// Ports:
//   clk  fast (upsampled-rate) clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pulse_shape_fir_if.slave: en/in_valid/in_data in, out_valid/out_data out
module pulse_shape_fir #(
  parameter int OUT_W  = 12,
  parameter int COEF_W = 8
) (
  input logic              clk,
  input logic              rst,
  pulse_shape_fir_if.slave bus
);

  // 11 bits hold every product and every partial/final sum without loss
  // (worst case on paper is |544|).
  localparam int SUM_W = 11;
  localparam int TAPS  = 9;

  localparam logic signed [COEF_W-1:0] C_TAP [TAPS] = '{
    COEF_W'(-3), COEF_W'(0), COEF_W'(21), COEF_W'(64), COEF_W'(96),
    COEF_W'(64), COEF_W'(21), COEF_W'(0), COEF_W'(-3)
  };

  logic signed [1:0]       r_x [TAPS];
  logic signed [SUM_W-1:0] r_p [3];
  logic                    r_v0;
  logic                    r_v1;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;

  logic                    w_accept;
  logic signed [SUM_W-1:0] w_prod [TAPS];
  logic signed [SUM_W-1:0] w_psum [3];
  logic signed [OUT_W-1:0] w_y;

  assign w_accept = bus.en & bus.in_valid;

  // Sign-extend both operands to the sum width before multiplying so the
  // product is exact and signed.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_prod[k] = SUM_W'(r_x[k]) * SUM_W'(C_TAP[k]);
    end
    for (int g = 0; g < 3; g++) begin
      w_psum[g] = w_prod[3*g] + w_prod[3*g+1] + w_prod[3*g+2];
    end
  end

  assign w_y = OUT_W'(r_p[0]) + OUT_W'(r_p[1]) + OUT_W'(r_p[2]);

  // Delay line advances only on accept; it never inserts zeros itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
    end else if (w_accept) begin
      r_x[0] <= bus.in_data;
      for (int k = 1; k < TAPS; k++) begin
        r_x[k] <= r_x[k-1];
      end
    end
  end

  // Pipeline stages run every clock so in-flight samples drain after en drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        r_p[g] <= '0;
      end
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      for (int g = 0; g < 3; g++) begin
        r_p[g] <= w_psum[g];
      end
      r_v0        <= w_accept;
      r_v1        <= r_v0;
      r_out_valid <= r_v1;
      r_out_data  <= w_y;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_pulse_shape_fir.sv
// tb/tb_pulse_shape_fir.sv - scoreboard bench for pulse_shape_fir
module tb_pulse_shape_fir;

  localparam int OUT_W = 12;

  typedef struct {
    int val;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];
  int   obs_q [$];
  int   mx [9];
  int   coef [9] = '{-3, 0, 21, 64, 96, 64, 21, 0, -3};

  pulse_shape_fir_if #(.OUT_W(OUT_W)) bus ();

  pulse_shape_fir #(.OUT_W(OUT_W), .COEF_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) mx[k] = 0;
    sb.delete();
  endtask

  // Inputs change on the falling edge; an accepted sample is seen on the
  // next rising edge (E0) and its result is due at E2, i.e. cyc+3 here.
  task automatic drive(input bit e, input bit v, input logic signed [1:0] d);
    int acc;
    exp_t x;
    @(negedge clk);
    bus.en       = e;
    bus.in_valid = v;
    bus.in_data  = d;
    if (e && v) begin
      for (int k = 8; k > 0; k--) mx[k] = mx[k-1];
      mx[0] = int'(d);
      acc = 0;
      for (int k = 0; k < 9; k++) acc += mx[k] * coef[k];
      x.val = acc;
      x.due = cyc + 3;
      sb.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'sb00);
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      obs_q.push_back(int'(bus.out_data));
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'(bus.out_data), e.val);
        chk("out_latency", cyc, e.due);
      end
    end
  end

  initial begin
    int imp_tab [9] = '{-3, 0, 21, 64, 96, 64, 21, 0, -3};
    int dc_tab  [9] = '{-3, -3, 18, 82, 178, 242, 263, 263, 260};
    logic [OUT_W-1:0] raw;

    bus.en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 2'sb00;
    model_clear();

    #12;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_out_data", int'(bus.out_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // positive impulse
    obs_q.delete();
    drive(1'b1, 1'b1, 2'sb01);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 2'sb00);
    idle(4);
    chk("impulse_count", obs_q.size(), 9);
    for (int i = 0; i < 9 && i < obs_q.size(); i++) chk("impulse_tap", obs_q[i], imp_tab[i]);

    // negative impulse
    obs_q.delete();
    drive(1'b1, 1'b1, 2'sb11);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 2'sb00);
    idle(4);
    chk("neg_impulse_count", obs_q.size(), 9);
    for (int i = 0; i < 9 && i < obs_q.size(); i++) chk("neg_impulse_tap", obs_q[i], -imp_tab[i]);

    // DC +1 ramp to steady 260
    obs_q.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 2'sb01);
    idle(4);
    chk("dc_pos_count", obs_q.size(), 12);
    for (int i = 0; i < 9 && i < obs_q.size(); i++) chk("dc_pos_ramp", obs_q[i], dc_tab[i]);
    if (obs_q.size() == 12) chk("dc_pos_steady", obs_q[11], 260);

    // full-scale negative, no wrap
    obs_q.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 2'sb10);
    idle(1);
    raw = bus.out_data;
    chk("dc_neg_raw_bits", int'(raw), 'hDF8);
    idle(3);
    if (obs_q.size() == 12) chk("dc_neg_steady", obs_q[11], -520);
    else chk("dc_neg_count", obs_q.size(), 12);

    // gapped input after a zero flush
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, 2'sb00);
    idle(4);
    obs_q.delete();
    drive(1'b1, 1'b1, 2'sb01);
    drive(1'b1, 1'b0, 2'sb01);
    drive(1'b1, 1'b0, 2'sb11);
    drive(1'b1, 1'b1, 2'sb00);
    idle(5);
    chk("gap_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("gap_first", obs_q[0], -3);
      chk("gap_second", obs_q[1], 0);
    end

    // enable gating: ignored samples must not advance the line
    obs_q.delete();
    drive(1'b1, 1'b1, 2'sb01);
    drive(1'b1, 1'b1, 2'sb01);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'sb01);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 2'sb01);
    idle(4);
    chk("en_gate_count", obs_q.size(), 5);

    // random traffic
    for (int i = 0; i < 60; i++)
      drive(1'(($urandom_range(0, 3) != 0)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    idle(4);

    // asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'sb01);
    chk("pre_reset_valid", int'(bus.out_valid), 1);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("async_reset_valid", int'(bus.out_valid), 0);
    chk("async_reset_data", int'(bus.out_data), 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
    drive(1'b1, 1'b1, 2'sb01);
    idle(5);
    chk("post_reset_count", obs_q.size(), 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
